// File: rtl/arb_pkg.sv
// arb_pkg: shared types, default parameters and helpers for bus_arbiter.
//   arb_state_t  : grant FSM states (IDLE -> ISSUE -> WAIT -> IDLE)
//   DEF_*        : default CHANNELS / WIDTH / TIMEOUT
//   next_index() : cyclic successor used for the round-robin pointer
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } arb_state_t;

   localparam int unsigned DEF_CHANNELS = 2;
   localparam int unsigned DEF_WIDTH    = 32;
   localparam int unsigned DEF_TIMEOUT  = 256;

   // Successor of idx in the cyclic order 0 .. n-1.
   function automatic int unsigned next_index(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/multiplexer.sv
// multiplexer: selects one WIDTH-bit slice of a packed payload bus.
//   data_in  : CHANNELS*WIDTH, channel i at [(CHANNELS-1-i)*WIDTH +: WIDTH]
//   sel      : channel index
//   data_out : selected slice; zero for an out-of-range index
module multiplexer
   import arb_pkg::*;
#(
   parameter int unsigned WIDTH    = DEF_WIDTH,
   parameter int unsigned CHANNELS = DEF_CHANNELS,
   localparam int unsigned SEL_W   = $clog2(CHANNELS)
) (
   input  logic [CHANNELS*WIDTH-1:0] data_in,
   input  logic [SEL_W-1:0]          sel,
   output logic [WIDTH-1:0]          data_out
);

   always_comb begin
      data_out = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (sel == SEL_W'(i)) begin
            data_out = data_in[(CHANNELS-1-i)*WIDTH +: WIDTH];
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter sharing one memory/bus port among CHANNELS requesters.
// The grant is held for a whole transaction (issue handshake, then response).
//   clock, reset      : rising-edge clock, asynchronous active-high reset
//   req               : per-requester request
//   req_payload       : requester i at [(CHANNELS-1-i)*WIDTH +: WIDTH]
//   grant / sel       : one-hot owner (0 when idle) / owner index
//   mem_valid         : request to shared port (ISSUE state)
//   mem_payload       : owner's payload, combinational from sel
//   mem_ready/mem_resp: shared port accept / completion
//   done              : one-cycle completion pulse to the owner
//   error             : watchdog abort pulse
// Optional feature: define ARB_TIMEOUT_EN to enable the TIMEOUT-cycle watchdog;
// without it error is tied low and a transaction may wait forever.
module bus_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned CHANNELS = DEF_CHANNELS,
   parameter int unsigned WIDTH    = DEF_WIDTH,
   parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [CHANNELS-1:0]          req,
   input  logic [CHANNELS*WIDTH-1:0]    req_payload,
   output logic [CHANNELS-1:0]          grant,
   output logic [$clog2(CHANNELS)-1:0]  sel,
   output logic                         mem_valid,
   output logic [WIDTH-1:0]             mem_payload,
   input  logic                         mem_ready,
   input  logic                         mem_resp,
   output logic [CHANNELS-1:0]          done,
   output logic                         error
);

   localparam int unsigned SEL_W = $clog2(CHANNELS);

   arb_state_t          state_q, state_d;
   logic [SEL_W-1:0]    owner_q, owner_d;
   logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [CHANNELS-1:0] done_q, done_d;
   logic                complete;
   logic                abort;

   // First asserted request at or after ptr, scanning cyclically.
   function automatic logic [SEL_W-1:0] rr_pick(input logic [CHANNELS-1:0] r,
                                                input logic [SEL_W-1:0]    ptr);
      logic [SEL_W-1:0] win;
      logic             found;
      int unsigned      idx;
      win   = ptr;
      found = 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         idx = (32'(ptr) + i) % CHANNELS;
         if (!found && r[idx]) begin
            win   = SEL_W'(idx);
            found = 1'b1;
         end
      end
      return win;
   endfunction

   // A same-cycle ready+resp in ISSUE completes without visiting WAIT.
   assign complete = ((state_q == ISSUE) && mem_ready && mem_resp) ||
                     ((state_q == WAIT) && mem_resp);

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

   logic [TMR_W-1:0] timer_q, timer_d;
   logic             error_q;

   // timer_q counts cycles spent in ISSUE/WAIT, starting at 0 on ISSUE entry.
   assign timer_d = (state_q == IDLE) ? '0 : timer_q + 1'b1;
   // Completion wins over a timeout landing in the same cycle.
   assign abort   = (state_q != IDLE) && !complete && (timer_q == TMR_W'(TIMEOUT - 1));
   assign error   = error_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         timer_q <= '0;
         error_q <= 1'b0;
      end else begin
         timer_q <= timer_d;
         error_q <= abort;
      end
   end
`else
   assign abort = 1'b0;
   assign error = 1'b0;
`endif

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         rr_ptr_q <= '0;
         done_q   <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         done_q   <= done_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      done_d   = '0;
      unique case (state_q)
         IDLE: begin
            if (|req) begin
               owner_d = rr_pick(req, rr_ptr_q);
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (complete || abort) state_d = IDLE;
            else if (mem_ready)    state_d = WAIT;
         end
         WAIT: begin
            if (complete || abort) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (complete || abort) begin
         rr_ptr_d = SEL_W'(next_index(32'(owner_q), CHANNELS));
      end
      if (complete) begin
         done_d[owner_q] = 1'b1;
      end
   end

   // Outputs.
   always_comb begin
      grant     = '0;
      mem_valid = 1'b0;
      if (state_q != IDLE) grant[owner_q] = 1'b1;
      if (state_q == ISSUE) mem_valid = 1'b1;
   end

   assign sel  = owner_q;
   assign done = done_q;

   multiplexer #(
      .WIDTH    (WIDTH),
      .CHANNELS (CHANNELS)
   ) u_payload_mux (
      .data_in  (req_payload),
      .sel      (owner_q),
      .data_out (mem_payload)
   );

endmodule
